// File: rtl/cache_hier_model.sv
// Tag-only timing/hit model of a split L1 (I/D) plus unified L2 cache hierarchy.
// One request at a time; reports L1/L2 hit flags and keeps saturating statistics.
module cache_hier_model #(
    parameter int ADDR_W   = 32,
    parameter int L1_BLOCK = 16,
    parameter int L1_LINES = 64,
    parameter int L1_WAYS  = 2,
    parameter int L2_BLOCK = 32,
    parameter int L2_LINES = 256,
    parameter int L2_WAYS  = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_instr,
    input  logic              flush,
    output logic              resp_valid,
    output logic              resp_l1_hit,
    output logic              resp_l2_hit,
    output logic [CNT_W-1:0]  l1i_acc,
    output logic [CNT_W-1:0]  l1i_miss,
    output logic [CNT_W-1:0]  l1d_acc,
    output logic [CNT_W-1:0]  l1d_miss,
    output logic [CNT_W-1:0]  l2_acc,
    output logic [CNT_W-1:0]  l2_miss
);
    localparam int L1_SETS   = L1_LINES / L1_WAYS;
    localparam int L1_OFF_W  = $clog2(L1_BLOCK);
    localparam int L1_IDX_W  = $clog2(L1_SETS);
    localparam int L1_TAG_W  = ADDR_W - L1_IDX_W - L1_OFF_W;
    localparam int L1_SET_IW = (L1_IDX_W > 0) ? L1_IDX_W : 1;
    localparam int L1_PTR_W  = (L1_WAYS > 1) ? $clog2(L1_WAYS) : 1;

    localparam int L2_SETS   = L2_LINES / L2_WAYS;
    localparam int L2_OFF_W  = $clog2(L2_BLOCK);
    localparam int L2_IDX_W  = $clog2(L2_SETS);
    localparam int L2_TAG_W  = ADDR_W - L2_IDX_W - L2_OFF_W;
    localparam int L2_SET_IW = (L2_IDX_W > 0) ? L2_IDX_W : 1;
    localparam int L2_PTR_W  = (L2_WAYS > 1) ? $clog2(L2_WAYS) : 1;

    localparam logic [ADDR_W-1:0] L1_SET_MASK = ADDR_W'(L1_SETS - 1);
    localparam logic [ADDR_W-1:0] L2_SET_MASK = ADDR_W'(L2_SETS - 1);

    typedef enum logic [2:0] {IDLE, L1_LK, L2_LK, FILL, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                instr_q;
    logic                resp_l1_hit_q, resp_l1_hit_d;
    logic                resp_l2_hit_q, resp_l2_hit_d;

    // Index 0 is L1D, index 1 is L1I (selected directly by the latched instr flag).
    logic                l1_valid_q [2][L1_SETS][L1_WAYS];
    logic [L1_TAG_W-1:0] l1_tag_q   [2][L1_SETS][L1_WAYS];
    logic [L1_PTR_W-1:0] l1_ptr_q   [2][L1_SETS];
    logic                l2_valid_q [L2_SETS][L2_WAYS];
    logic [L2_TAG_W-1:0] l2_tag_q   [L2_SETS][L2_WAYS];
    logic [L2_PTR_W-1:0] l2_ptr_q   [L2_SETS];

    logic [L1_SET_IW-1:0] l1_set;
    logic [L1_TAG_W-1:0]  l1_tag;
    logic [L2_SET_IW-1:0] l2_set;
    logic [L2_TAG_W-1:0]  l2_tag;

    logic                l1_hit, l1_inv_found;
    logic [L1_PTR_W-1:0] l1_vic, l1_ptr_next;
    logic                l2_hit, l2_inv_found;
    logic [L2_PTR_W-1:0] l2_vic, l2_ptr_next;

    logic       do_flush, do_accept, l1_fill, l2_fill;
    logic [5:0] cnt_inc;

    assign l1_set = L1_SET_IW'((addr_q >> L1_OFF_W) & L1_SET_MASK);
    assign l1_tag = L1_TAG_W'(addr_q >> (L1_OFF_W + L1_IDX_W));
    assign l2_set = L2_SET_IW'((addr_q >> L2_OFF_W) & L2_SET_MASK);
    assign l2_tag = L2_TAG_W'(addr_q >> (L2_OFF_W + L2_IDX_W));

    // Downward scan leaves the lowest-index invalid way as the victim.
    always_comb begin
        l1_hit       = 1'b0;
        l1_inv_found = 1'b0;
        l1_vic       = l1_ptr_q[instr_q][l1_set];
        for (int w = L1_WAYS - 1; w >= 0; w--) begin
            if (l1_valid_q[instr_q][l1_set][w] && (l1_tag_q[instr_q][l1_set][w] == l1_tag))
                l1_hit = 1'b1;
            if (!l1_valid_q[instr_q][l1_set][w]) begin
                l1_vic       = L1_PTR_W'(w);
                l1_inv_found = 1'b1;
            end
        end
        l1_ptr_next = (l1_ptr_q[instr_q][l1_set] == L1_PTR_W'(L1_WAYS - 1)) ?
                      '0 : l1_ptr_q[instr_q][l1_set] + 1'b1;
    end

    always_comb begin
        l2_hit       = 1'b0;
        l2_inv_found = 1'b0;
        l2_vic       = l2_ptr_q[l2_set];
        for (int w = L2_WAYS - 1; w >= 0; w--) begin
            if (l2_valid_q[l2_set][w] && (l2_tag_q[l2_set][w] == l2_tag))
                l2_hit = 1'b1;
            if (!l2_valid_q[l2_set][w]) begin
                l2_vic       = L2_PTR_W'(w);
                l2_inv_found = 1'b1;
            end
        end
        l2_ptr_next = (l2_ptr_q[l2_set] == L2_PTR_W'(L2_WAYS - 1)) ?
                      '0 : l2_ptr_q[l2_set] + 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        resp_l1_hit_d = resp_l1_hit_q;
        resp_l2_hit_d = resp_l2_hit_q;
        do_flush      = 1'b0;
        do_accept     = 1'b0;
        l1_fill       = 1'b0;
        l2_fill       = 1'b0;
        cnt_inc       = '0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    do_flush = 1'b1;
                end else if (req_valid) begin
                    do_accept = 1'b1;
                    state_d   = L1_LK;
                end
            end
            L1_LK: begin
                cnt_inc[instr_q ? 0 : 2] = 1'b1;
                if (l1_hit) begin
                    resp_l1_hit_d = 1'b1;
                    resp_l2_hit_d = 1'b0;
                    state_d       = RESP;
                end else begin
                    cnt_inc[instr_q ? 1 : 3] = 1'b1;
                    state_d = L2_LK;
                end
            end
            L2_LK: begin
                cnt_inc[4] = 1'b1;
                if (l2_hit) begin
                    l1_fill       = 1'b1;
                    resp_l1_hit_d = 1'b0;
                    resp_l2_hit_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_inc[5] = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                l1_fill       = 1'b1;
                l2_fill       = 1'b1;
                resp_l1_hit_d = 1'b0;
                resp_l2_hit_d = 1'b0;
                state_d       = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_l1_hit = resp_l1_hit_q;
    assign resp_l2_hit = resp_l2_hit_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            instr_q       <= 1'b0;
            resp_l1_hit_q <= 1'b0;
            resp_l2_hit_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            resp_l1_hit_q <= resp_l1_hit_d;
            resp_l2_hit_q <= resp_l2_hit_d;
            if (do_accept) begin
                addr_q  <= req_addr;
                instr_q <= req_instr;
            end
        end
    end

    // Valid bits and victim pointers need reset and single-cycle flush; tags do not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 2; c++)
                for (int s = 0; s < L1_SETS; s++) begin
                    l1_ptr_q[c][s] <= '0;
                    for (int w = 0; w < L1_WAYS; w++) l1_valid_q[c][s][w] <= 1'b0;
                end
            for (int s = 0; s < L2_SETS; s++) begin
                l2_ptr_q[s] <= '0;
                for (int w = 0; w < L2_WAYS; w++) l2_valid_q[s][w] <= 1'b0;
            end
        end else if (do_flush) begin
            for (int c = 0; c < 2; c++)
                for (int s = 0; s < L1_SETS; s++) begin
                    l1_ptr_q[c][s] <= '0;
                    for (int w = 0; w < L1_WAYS; w++) l1_valid_q[c][s][w] <= 1'b0;
                end
            for (int s = 0; s < L2_SETS; s++) begin
                l2_ptr_q[s] <= '0;
                for (int w = 0; w < L2_WAYS; w++) l2_valid_q[s][w] <= 1'b0;
            end
        end else begin
            if (l1_fill) begin
                l1_valid_q[instr_q][l1_set][l1_vic] <= 1'b1;
                if (!l1_inv_found) l1_ptr_q[instr_q][l1_set] <= l1_ptr_next;
            end
            if (l2_fill) begin
                l2_valid_q[l2_set][l2_vic] <= 1'b1;
                if (!l2_inv_found) l2_ptr_q[l2_set] <= l2_ptr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (l1_fill) l1_tag_q[instr_q][l1_set][l1_vic] <= l1_tag;
        if (l2_fill) l2_tag_q[l2_set][l2_vic] <= l2_tag;
    end

    // Counter order: l1i_acc, l1i_miss, l1d_acc, l1d_miss, l2_acc, l2_miss.
    for (genvar gi = 0; gi < 6; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q;
            if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        end
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) cnt_q <= '0;
            else      cnt_q <= cnt_d;
        end
    end

    assign l1i_acc  = g_cnt[0].cnt_q;
    assign l1i_miss = g_cnt[1].cnt_q;
    assign l1d_acc  = g_cnt[2].cnt_q;
    assign l1d_miss = g_cnt[3].cnt_q;
    assign l2_acc   = g_cnt[4].cnt_q;
    assign l2_miss  = g_cnt[5].cnt_q;
endmodule

// File: tb/tb_cache_hier_model.sv
// Directed bench for cache_hier_model: scoreboard of expected hit flags/latency,
// plus a CNT_W=4 instance sharing the stimulus to exercise counter saturation.
module tb_cache_hier_model;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_instr = 1'b0;
    logic        flush = 1'b0;

    logic        req_ready, resp_valid, resp_l1_hit, resp_l2_hit;
    logic [31:0] l1i_acc, l1i_miss, l1d_acc, l1d_miss, l2_acc, l2_miss;
    logic        s_req_ready, s_resp_valid, s_resp_l1_hit, s_resp_l2_hit;
    logic [3:0]  s_l1i_acc, s_l1i_miss, s_l1d_acc, s_l1d_miss, s_l2_acc, s_l2_miss;

    cache_hier_model dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_instr(req_instr), .flush(flush),
        .resp_valid(resp_valid), .resp_l1_hit(resp_l1_hit), .resp_l2_hit(resp_l2_hit),
        .l1i_acc(l1i_acc), .l1i_miss(l1i_miss), .l1d_acc(l1d_acc), .l1d_miss(l1d_miss),
        .l2_acc(l2_acc), .l2_miss(l2_miss)
    );

    cache_hier_model #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_addr(req_addr), .req_instr(req_instr), .flush(flush),
        .resp_valid(s_resp_valid), .resp_l1_hit(s_resp_l1_hit), .resp_l2_hit(s_resp_l2_hit),
        .l1i_acc(s_l1i_acc), .l1i_miss(s_l1i_miss), .l1d_acc(s_l1d_acc), .l1d_miss(s_l1d_miss),
        .l2_acc(s_l2_acc), .l2_miss(s_l2_miss)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        instr;
        logic        l1;
        logic        l2;
        int          lat;
        int          acc_cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int m_l1i_acc, m_l1i_miss, m_l1d_acc, m_l1d_miss, m_l2_acc, m_l2_miss;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat4(input int v);
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_l1i_acc"},  l1i_acc,  32'(m_l1i_acc));
        check({tag, "_l1i_miss"}, l1i_miss, 32'(m_l1i_miss));
        check({tag, "_l1d_acc"},  l1d_acc,  32'(m_l1d_acc));
        check({tag, "_l1d_miss"}, l1d_miss, 32'(m_l1d_miss));
        check({tag, "_l2_acc"},   l2_acc,   32'(m_l2_acc));
        check({tag, "_l2_miss"},  l2_miss,  32'(m_l2_miss));
        check({tag, "_s_l1d_acc"},  {28'd0, s_l1d_acc},  sat4(m_l1d_acc));
        check({tag, "_s_l1d_miss"}, {28'd0, s_l1d_miss}, sat4(m_l1d_miss));
        check({tag, "_s_l2_acc"},   {28'd0, s_l2_acc},   sat4(m_l2_acc));
        check({tag, "_s_l2_miss"},  {28'd0, s_l2_miss},  sat4(m_l2_miss));
    endtask

    // Response monitor: every resp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            checks++;
            assert (sb.size() != 0)
            else begin
                failures++;
                $error("FAIL unexpected_resp observed=resp_valid expected=no_response");
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                $display("txn addr=0x%08h instr=%0d l1_hit=%0d l2_hit=%0d lat=%0d",
                         e.addr, e.instr, resp_l1_hit, resp_l2_hit, cyc - e.acc_cyc);
                check("resp_l1_hit", {31'd0, resp_l1_hit}, {31'd0, e.l1});
                check("resp_l2_hit", {31'd0, resp_l2_hit}, {31'd0, e.l2});
                check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                check("small_resp_valid", {31'd0, s_resp_valid}, 32'd1);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic ins, input logic e1, input logic e2);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_addr  = a;
        req_instr = ins;
        req_valid = 1'b1;
        e.addr = a; e.instr = ins; e.l1 = e1; e.l2 = e2;
        e.lat = e1 ? 2 : (e2 ? 3 : 4);
        e.acc_cyc = cyc;
        sb.push_back(e);
        if (ins) begin
            m_l1i_acc++;
            if (!e1) m_l1i_miss++;
        end else begin
            m_l1d_acc++;
            if (!e1) m_l1d_miss++;
        end
        if (!e1) begin
            m_l2_acc++;
            if (!e2) m_l2_miss++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        check("resp_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic zero_model();
        m_l1i_acc = 0; m_l1i_miss = 0; m_l1d_acc = 0;
        m_l1d_miss = 0; m_l2_acc = 0; m_l2_miss = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_model();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_l1_flag", {31'd0, resp_l1_hit}, 32'd0);
        check("reset_l2_flag", {31'd0, resp_l2_hit}, 32'd0);
        check_counters("reset");

        // Cold miss, same-line hit, then the I-side sees the line in L2.
        send(32'h0000_1000, 1'b0, 1'b0, 1'b0);
        send(32'h0000_100C, 1'b0, 1'b1, 1'b0);
        send(32'h0000_1000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("hold_l2_flag", {31'd0, resp_l2_hit}, 32'd1);
        check_counters("basic");

        // Three tags into L1D set 0 (2 ways) force round-robin evictions.
        send(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0200, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0400, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0000, 1'b0, 1'b0, 1'b1);
        send(32'h0000_0400, 1'b0, 1'b1, 1'b0);

        // Flush wins over a simultaneous request; caches empty, counters kept.
        send(32'h0000_1000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        req_addr = 32'h0000_1000; req_instr = 1'b0;
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        check("flush_not_accepted", {31'd0, req_ready}, 32'd1);
        repeat (6) @(negedge clk);
        send(32'h0000_1000, 1'b0, 1'b0, 1'b0);
        check_counters("flush");

        // 17 distinct cold misses push the 4-bit counters into saturation.
        for (int k = 0; k < 17; k++) send(32'h0001_0000 + 32'(k) * 32'h20, 1'b0, 1'b0, 1'b0);
        check_counters("sat");
        check("sat_s_l1d_acc_15", {28'd0, s_l1d_acc}, 32'd15);
        check("sat_s_l1d_miss_15", {28'd0, s_l1d_miss}, 32'd15);

        // Reset while in L2_LK drops the request with no response.
        @(negedge clk);
        req_addr = 32'h0002_0000; req_instr = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        zero_model();
        repeat (6) @(negedge clk);
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_l1_flag", {31'd0, resp_l1_hit}, 32'd0);
        check("midrst_l2_flag", {31'd0, resp_l2_hit}, 32'd0);
        check_counters("midrst");

        // Reset also invalidated the tags, so a previously cached line misses.
        send(32'h0000_1000, 1'b0, 1'b0, 1'b0);
        check_counters("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
